plane_recip_div: RTL

- Iterative reciprocal divider that feeds the 3D floor-plane stage of the VGA demo.
- Once per scanline it computes recip = floor(2^SHIFT / denom), one quotient bit per clock, saturating to the output width.
- Started during the active line at h_count == H_DISPLAY-16; result is sampled as the per-line u-step at h_count == H_DISPLAY, so worst-case latency must be under 16 clocks.

---
 rtl/plane_recip_div.sv | 139 +++++++++++++
 1 files changed

// File: rtl/plane_recip_div.sv
// plane_recip_div
//   Iterative reciprocal divider for the floor-plane stage. Computes
//   recip = floor(2^SHIFT / denom), producing one quotient bit per clock.
//   The result saturates to all-ones when the quotient cannot fit in RECIP_W
//   bits, and also when denom == 0.
//   Optional macro PLANE_RECIP_ROUND_EN: runs one extra guard-bit iteration
//   and rounds the result half up. Latency becomes RECIP_W+2 clocks instead
//   of RECIP_W+1.
//
// Ports
//   clk48  in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a new division; it is sampled on every clock, so a
//               start while busy aborts the current division and restarts
//   denom  in   [DENOM_W-1:0] unsigned divisor, captured when start is high
//   recip  out  [RECIP_W-1:0] registered quotient; it changes only when
//               done is asserted
//   busy   out  high while an operation is in flight, including the done cycle
//   done   out  one-cycle pulse; recip is valid from this cycle onward
module plane_recip_div #(
  parameter int unsigned DENOM_W = 10,
  parameter int unsigned RECIP_W = 11,
  parameter int unsigned SHIFT   = 16
) (
  input  logic               clk48,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DENOM_W-1:0] denom,
  output logic [RECIP_W-1:0] recip,
  output logic               busy,
  output logic               done
);

`ifdef PLANE_RECIP_ROUND_EN
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned EXTRA = 0;
`endif
  localparam int unsigned NITER = RECIP_W + EXTRA;
  localparam int unsigned CNT_W = (NITER > 1) ? $clog2(NITER) : 1;
  // Counter value at which the numerator's single set bit is shifted in.
  localparam int unsigned NPOS  = SHIFT + EXTRA;
  // Partial remainder at the start: the numerator bits above the quotient
  // window, i.e. 2^SHIFT >> RECIP_W.
  localparam logic [DENOM_W:0] R_INIT = {{DENOM_W{1'b0}}, 1'b1} << (SHIFT - RECIP_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [DENOM_W-1:0] d_reg;
  logic               ovf;
  logic [DENOM_W:0]   rem;
  logic [NITER-2:0]   q_sh;
  logic [CNT_W-1:0]   cnt;

  logic               nbit;
  logic [DENOM_W+1:0] r_shift;
  logic [DENOM_W:0]   r_diff;
  logic               qbit;
  logic [NITER-1:0]   q_next;
  logic               last;
  logic [RECIP_W-1:0] result;

  always_comb begin
    nbit    = (32'(cnt) == NPOS);
    r_shift = {rem, nbit};
    qbit    = (r_shift >= {2'b00, d_reg});
    // Modular subtraction in DENOM_W+1 bits: when qbit is set and no
    // overflow is flagged, the true difference is below D, so nothing is lost.
    r_diff  = r_shift[DENOM_W:0] - {1'b0, d_reg};
    // q_sh holds every bit except the one produced this cycle.
    q_next  = {q_sh, qbit};
    last    = (cnt == '0);
`ifdef PLANE_RECIP_ROUND_EN
    begin : round_blk
      logic [RECIP_W:0] sum;
      sum    = {1'b0, q_next[NITER-1:1]} + (RECIP_W+1)'(q_next[0]);
      result = ovf ? '1 : (sum[RECIP_W] ? '1 : sum[RECIP_W-1:0]);
    end
`else
    result  = ovf ? '1 : q_next;
`endif
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      d_reg <= '0;
      ovf   <= 1'b0;
      rem   <= '0;
      q_sh  <= '0;
      cnt   <= '0;
      recip <= '0;
      done  <= 1'b0;
    end else if (start) begin
      // A start in any state recaptures and restarts. An operation that is
      // aborted here never gets its done pulse.
      d_reg <= denom;
      ovf   <= (denom == '0) || ({1'b0, denom} <= R_INIT);
      rem   <= R_INIT;
      q_sh  <= '0;
      cnt   <= CNT_W'(NITER - 1);
      state <= S_RUN;
      done  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          rem  <= qbit ? r_diff : r_shift[DENOM_W:0];
          q_sh <= q_next[NITER-2:0];
          if (last) begin
            // The final bit is folded into result in this same cycle, so
            // recip and done appear together when DONE is entered.
            state <= S_DONE;
            recip <= result;
            done  <= 1'b1;
          end else begin
            cnt  <= cnt - 1'b1;
            done <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
